fifo_data_source: RTL and testbench
===================================

Name: fifo_data_source

Overview:
- Producer end of the 16-bit FIFO data path that NIOS reads through its input PIO.
- Buffers ultrasonic sample words from the acquisition logic in an internal FIFO.
- Presents the head word on out_port, which drives the PIO in_port.
- Advances to the next word when software pulses a read-acknowledge line from an output PIO.
- Exports empty/full/count/overflow status for a second status PIO.

Parameters:
- DATA_WIDTH, 16: sample/out_port width; must equal the PIO in_port width.
- DEPTH_LOG2, 9: FIFO depth = 2**DEPTH_LOG2 words (default 512).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- sample_data, input, DATA_WIDTH: sample word from the acquisition logic.
- sample_valid, input, 1: single-cycle push request for sample_data.
- flush, input, 1: synchronous FIFO clear driven from a software control bit.
- rd_ack, input, 1: level from the output PIO; a rising edge pops the head word.
- out_port, output, DATA_WIDTH: registered head word of the FIFO; 0 when empty.
- empty, output, 1: FIFO holds 0 words.
- full, output, 1: FIFO holds 2**DEPTH_LOG2 words.
- count, output, DEPTH_LOG2+1: number of words held.
- overflow, output, 1: sticky flag; a push was dropped while full.

Behaviour:
- Reset (reset=1 at a clk edge):
  - wr_ptr = rd_ptr = count = 0.
  - out_port = 0, empty = 1, full = 0, overflow = 0.
  - rd_ack_q = 0.
  - RAM contents are don't-care.
- Reset dominates all other inputs in the same cycle. Reset mid-operation discards all stored words.
- Storage: dual-pointer circular RAM. Pointers are DEPTH_LOG2 bits and wrap naturally from 2**DEPTH_LOG2-1 to 0. Full/empty are derived from count, not from pointer compare.
- Pop detect: rd_ack_q <= rd_ack every cycle; pop_req = rd_ack & ~rd_ack_q.
  - A level held high pops exactly once.
  - Software must return rd_ack to 0 before the next pop.
- Push: accepted when sample_valid=1 and (full=0 or pop accepted in the same cycle). Writes RAM[wr_ptr] and increments wr_ptr.
- Dropped push: sample_valid=1, full=1 and no pop that cycle. Data is discarded, overflow <= 1, and count does not change.
- Pop: accepted when pop_req=1 and empty=0; increments rd_ptr. A pop_req while empty is ignored: no pointer change, no error flag.
- Simultaneous push+pop:
  - count unchanged; both pointers advance.
  - When full, the push is accepted in that cycle.
  - When empty, only the push takes effect.
- count: +1 on a push-only cycle, -1 on a pop-only cycle, unchanged otherwise. empty = (count==0) and full = (count==2**DEPTH_LOG2), both registered alongside count.
- out_port (first-word-fall-through, registered):
  - Always equals RAM[rd_ptr] from the cycle after any pointer or count change.
  - First push into an empty FIFO appears on out_port 1 cycle after the push cycle; empty deasserts in the same cycle.
  - After an accepted pop, the next word appears on out_port 1 cycle later.
  - When the pop empties the FIFO, out_port = 0 and empty = 1 on that next cycle.
- flush=1:
  - Same effect as reset on pointers, count, out_port, empty and full.
  - Also clears overflow.
  - Does not clear rd_ack_q.
  - A push or pop in the flush cycle is discarded.
- No state machine beyond the pointer/count datapath. Implementations must not add extra read latency on out_port.

Optional Feature:
- Macro: FIFO_DATA_SOURCE_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [15:0].
  - Increments once per dropped push and saturates at 16'hFFFF, with no wrap.
  - Reset and flush clear it to 0.
- Undefined:
  - Port and counter are absent.
  - overflow is the only loss indication.

Test Plan:
- Reset, then push 16'h1234:
  - out_port=16'h1234, count=1, empty=0 exactly 1 cycle after the push cycle.
  - out_port=0 before that.
- Push 3 words (A1,A2,A3), then hold rd_ack high for 5 cycles:
  - Exactly one pop; out_port=A2, count=2.
  - Drop rd_ack and raise it again: out_port=A3, count=1.
- With DEPTH_LOG2=2, push 5 words 0..4 with no pops:
  - count=4, full=1, overflow=1; word 4 is lost.
  - Drain with 4 rd_ack edges: read order 0,1,2,3, then empty=1 and out_port=0.
- Full FIFO (DEPTH_LOG2=2), sample_valid and rd_ack rising edge in the same cycle:
  - count stays 4, overflow stays 0.
  - Head advances; the new word is last out.
- Pointer wrap: with DEPTH_LOG2=2, interleave 10 pushes (values 10..19) and pops with count≤3:
  - out_port sequence is 10..19 in order across the wraparound.
- Reset asserted mid-stream with count=3 and overflow=1:
  - Next cycle count=0, empty=1, out_port=0, overflow=0.
  - With FIFO_DATA_SOURCE_DROP_CNT_EN defined: drop_count=0.
  - A subsequent flush of an empty FIFO changes nothing.

Source files
------------

// File: rtl/fifo_data_source.sv
// ---------------------------------------------------------------------------
// fifo_data_source
//
// Producer end of the sample FIFO that software reads through a PIO. Sample
// words pushed by the acquisition logic are buffered in a circular RAM. The
// head word is presented, registered, on out_port. A rising edge on rd_ack
// pops that word. Status (empty/full/count/overflow) goes to a status PIO.
//
// Parameters:
//   DATA_WIDTH  - sample / out_port width (must match the PIO in_port width)
//   DEPTH_LOG2  - FIFO depth is 2**DEPTH_LOG2 words
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset
//   sample_data  - sample word from the acquisition logic
//   sample_valid - single-cycle push request
//   flush        - synchronous FIFO clear (also clears overflow / drop_count)
//   rd_ack       - read-acknowledge level; a rising edge pops the head word
//   out_port     - registered head word, 0 when empty
//   empty        - FIFO holds no words
//   full         - FIFO holds 2**DEPTH_LOG2 words
//   count        - number of words held
//   overflow     - sticky: a push was dropped while full
//   drop_count   - saturating dropped-push counter (only when the macro
//                  FIFO_DATA_SOURCE_DROP_CNT_EN is defined)
// ---------------------------------------------------------------------------
module fifo_data_source #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    input  logic                  flush,
    input  logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
`ifdef FIFO_DATA_SOURCE_DROP_CNT_EN
    output logic [15:0]           drop_count,
`endif
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;
    logic                  r_rdAckQ;
    logic [DATA_WIDTH-1:0] r_outPort;

    logic                  w_popReq;
    logic                  w_popAcc;
    logic                  w_pushAcc;
    logic                  w_drop;
    logic [DEPTH_LOG2-1:0] w_wrPtrNext;
    logic [DEPTH_LOG2-1:0] w_rdPtrNext;
    logic [DEPTH_LOG2:0]   w_countNext;
    logic [DATA_WIDTH-1:0] w_outNext;

    // A held-high rd_ack pops once: only the 0->1 transition counts.
    assign w_popReq  = rd_ack & ~r_rdAckQ;
    assign w_popAcc  = w_popReq & ~r_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_pushAcc = sample_valid & (~r_full | w_popAcc);
    assign w_drop    = sample_valid & r_full & ~w_popAcc;

    // Next pointer/count values, shared by the state update and by the
    // look-ahead that keeps out_port free of extra read latency.
    always_comb begin
        w_wrPtrNext = w_pushAcc ? r_wrPtr + PTR_ONE : r_wrPtr;
        w_rdPtrNext = w_popAcc  ? r_rdPtr + PTR_ONE : r_rdPtr;
        w_countNext = r_count;
        if (w_pushAcc && !w_popAcc) begin
            w_countNext = r_count + CNT_ONE;
        end else if (!w_pushAcc && w_popAcc) begin
            w_countNext = r_count - CNT_ONE;
        end
    end

    // The word that will sit at the head after this edge. When the word being
    // written this cycle lands exactly at the new head (push into empty, or
    // push+pop with one word held) it is not in the RAM yet, so bypass it.
    always_comb begin
        w_outNext = '0;
        if (w_countNext != CNT_ZERO) begin
            if (w_pushAcc && (r_wrPtr == w_rdPtrNext)) begin
                w_outNext = sample_data;
            end else begin
                w_outNext = r_mem[w_rdPtrNext];
            end
        end
    end

    // Storage array has no reset; only words between the pointers matter.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_pushAcc) begin
            r_mem[r_wrPtr] <= sample_data;
        end
    end

    // Pointer/count/status datapath. Flush behaves like reset except that
    // the rd_ack edge detector keeps tracking the input level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_rdAckQ   <= 1'b0;
            r_outPort  <= '0;
        end else begin
            r_rdAckQ <= rd_ack;
            if (flush) begin
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_count    <= '0;
                r_empty    <= 1'b1;
                r_full     <= 1'b0;
                r_overflow <= 1'b0;
                r_outPort  <= '0;
            end else begin
                r_wrPtr   <= w_wrPtrNext;
                r_rdPtr   <= w_rdPtrNext;
                r_count   <= w_countNext;
                r_empty   <= (w_countNext == CNT_ZERO);
                r_full    <= (w_countNext == CNT_FULL);
                r_outPort <= w_outNext;
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_DATA_SOURCE_DROP_CNT_EN
    logic [15:0] r_dropCount;

    // Counts dropped pushes, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_dropCount <= '0;
        end else if (w_drop && (r_dropCount != 16'hFFFF)) begin
            r_dropCount <= r_dropCount + 16'd1;
        end
    end

    assign drop_count = r_dropCount;
`endif

    assign out_port = r_outPort;
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fifo_data_source.sv
// ---------------------------------------------------------------------------
// tb_fifo_data_source
//
// Drives fifo_data_source (4-word configuration) with directed sequences
// followed by randomized traffic. A queue-based reference model tracks the
// expected contents, and every output is compared after every clock edge.
// ---------------------------------------------------------------------------
module tb_fifo_data_source;

    localparam int DW    = 16;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          flush = 1'b0;
    logic          rd_ack = 1'b0;
    logic [DW-1:0] out_port;
    logic          empty;
    logic          full;
    logic [DL2:0]  count;
    logic          overflow;
`ifdef FIFO_DATA_SOURCE_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] modelQ[$];
    logic          modelOvf = 1'b0;
    logic          modelAckPrev = 1'b0;
    int            modelDrops = 0;

    fifo_data_source #(
        .DATA_WIDTH(DW),
        .DEPTH_LOG2(DL2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .flush(flush),
        .rd_ack(rd_ack),
        .out_port(out_port),
        .empty(empty),
        .full(full),
        .count(count),
`ifdef FIFO_DATA_SOURCE_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts it, reports a failure.
    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput(input string tag);
        logic [DW-1:0] expHead;
        expHead = (modelQ.size() > 0) ? modelQ[0] : '0;
        checkValue({tag, ".out_port"}, 32'(out_port), 32'(expHead));
        checkValue({tag, ".count"}, 32'(count), 32'(modelQ.size()));
        checkValue({tag, ".empty"}, 32'(empty), 32'(modelQ.size() == 0));
        checkValue({tag, ".full"}, 32'(full), 32'(modelQ.size() == DEPTH));
        checkValue({tag, ".overflow"}, 32'(overflow), 32'(modelOvf));
`ifdef FIFO_DATA_SOURCE_DROP_CNT_EN
        checkValue({tag, ".drop_count"}, 32'(drop_count), 32'(modelDrops));
`endif
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, check.
    task automatic applyStimulus(input string tag, input logic rst, input logic fl,
                                 input logic valid, input logic [DW-1:0] data, input logic ack);
        logic popReq;
        logic popOk;
        logic pushOk;
        reset        = rst;
        flush        = fl;
        sample_valid = valid;
        sample_data  = data;
        rd_ack       = ack;
        @(posedge clk);
        #1;
        if (rst) begin
            modelQ.delete();
            modelOvf     = 1'b0;
            modelAckPrev = 1'b0;
            modelDrops   = 0;
        end else begin
            popReq       = ack && !modelAckPrev;
            modelAckPrev = ack;
            if (fl) begin
                modelQ.delete();
                modelOvf   = 1'b0;
                modelDrops = 0;
            end else begin
                popOk  = popReq && (modelQ.size() > 0);
                pushOk = valid && ((modelQ.size() < DEPTH) || popOk);
                if (popOk) void'(modelQ.pop_front());
                if (pushOk) modelQ.push_back(data);
                if (valid && !pushOk) begin
                    modelOvf = 1'b1;
                    if (modelDrops < 65535) modelDrops++;
                end
            end
        end
        checkOutput(tag);
    endtask

    initial begin
        // Reset and first word fall-through
        applyStimulus("rst0", 1, 0, 0, '0, 0);
        applyStimulus("rst1", 1, 0, 0, '0, 0);
        checkValue("resetOut", 32'(out_port), 32'h0);
        applyStimulus("push1234", 0, 0, 1, 16'h1234, 0);
        checkValue("firstWordOut", 32'(out_port), 32'h1234);
        checkValue("firstWordCount", 32'(count), 32'd1);

        // Held rd_ack pops once, re-armed after dropping
        applyStimulus("flushA", 0, 1, 0, '0, 0);
        applyStimulus("pushA1", 0, 0, 1, 16'h00A1, 0);
        applyStimulus("pushA2", 0, 0, 1, 16'h00A2, 0);
        applyStimulus("pushA3", 0, 0, 1, 16'h00A3, 0);
        for (int i = 0; i < 5; i++) applyStimulus("ackHold", 0, 0, 0, '0, 1);
        checkValue("holdOnceOut", 32'(out_port), 32'h00A2);
        checkValue("holdOnceCount", 32'(count), 32'd2);
        applyStimulus("ackLow", 0, 0, 0, '0, 0);
        applyStimulus("ackRise", 0, 0, 0, '0, 1);
        checkValue("secondPopOut", 32'(out_port), 32'h00A3);
        checkValue("secondPopCount", 32'(count), 32'd1);
        applyStimulus("ackLow2", 0, 0, 0, '0, 0);

        // Overflow: five pushes into four slots, then drain
        applyStimulus("flushB", 0, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("fillOvf", 0, 0, 1, DW'(i), 0);
        checkValue("ovfFull", 32'(full), 32'd1);
        checkValue("ovfFlag", 32'(overflow), 32'd1);
        checkValue("ovfCount", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkValue("drainOrder", 32'(out_port), 32'(i));
            applyStimulus("drainRise", 0, 0, 0, '0, 1);
            applyStimulus("drainLow", 0, 0, 0, '0, 0);
        end
        checkValue("drainedEmpty", 32'(empty), 32'd1);
        checkValue("drainedOut", 32'(out_port), 32'h0);

        // Push and pop together while full
        applyStimulus("flushC", 0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("fillC", 0, 0, 1, DW'(16'h40 + i), 0);
        applyStimulus("fullPushPop", 0, 0, 1, 16'h0055, 1);
        checkValue("fullPPCount", 32'(count), 32'd4);
        checkValue("fullPPOvf", 32'(overflow), 32'd0);
        checkValue("fullPPHead", 32'(out_port), 32'h0041);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("drainCLow", 0, 0, 0, '0, 0);
            applyStimulus("drainCRise", 0, 0, 0, '0, 1);
        end
        applyStimulus("drainCLow2", 0, 0, 0, '0, 0);

        // Pointer wraparound with occupancy kept at or below three
        applyStimulus("flushD", 0, 1, 0, '0, 0);
        for (int v = 10; v < 20; v++) begin
            applyStimulus("wrapPush", 0, 0, 1, DW'(v), 0);
            if (count == 3) begin
                applyStimulus("wrapPop", 0, 0, 0, '0, 1);
                applyStimulus("wrapLow", 0, 0, 0, '0, 0);
            end
        end
        while (!empty && total < 5000) begin
            applyStimulus("wrapDrain", 0, 0, 0, '0, 1);
            applyStimulus("wrapDrainLow", 0, 0, 0, '0, 0);
        end

        // Mid-stream reset with count=3 and overflow set, then flush of empty
        for (int i = 0; i < 5; i++) applyStimulus("preRst", 0, 0, 1, DW'(16'h70 + i), 0);
        applyStimulus("preRstPop", 0, 0, 0, '0, 1);
        checkValue("preRstCount", 32'(count), 32'd3);
        checkValue("preRstOvf", 32'(overflow), 32'd1);
        applyStimulus("midRst", 1, 0, 1, 16'hDEAD, 1);
        checkValue("midRstCount", 32'(count), 32'd0);
        checkValue("midRstOvf", 32'(overflow), 32'd0);
        applyStimulus("flushEmpty", 0, 1, 0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand", ($urandom_range(99) == 0), ($urandom_range(49) == 0),
                          ($urandom_range(1) == 1), DW'($urandom), ($urandom_range(1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
